// File: rtl/phase_sequencer.sv
// Multi-cycle instruction phase sequencer: walks each instruction through
// fetch-wait, F, D, E, optional M and W, and counts retired instructions.
module phase_sequencer (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start,
    input  logic        hlt_req,
    input  logic        is_mem,
    input  logic        is_wb,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    output logic [4:0]  phase,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        ir_we,
    output logic        rf_we,
    output logic        hlt,
    output logic [31:0] retired
);

    localparam logic [4:0] PH_NONE = 5'b00000;
    localparam logic [4:0] PH_F    = 5'b00001;
    localparam logic [4:0] PH_D    = 5'b00010;
    localparam logic [4:0] PH_E    = 5'b00100;
    localparam logic [4:0] PH_M    = 5'b01000;
    localparam logic [4:0] PH_W    = 5'b10000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FWAIT,
        ST_F,
        ST_D,
        ST_E,
        ST_M,
        ST_W,
        ST_HALT
    } state_t;

    state_t      state;
    logic [31:0] retired_q;

    // Acks and start are only looked at in the states that wait for them.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state     <= ST_IDLE;
            retired_q <= '0;
        end else begin
            case (state)
                ST_IDLE:  if (start) state <= ST_FWAIT;
                ST_FWAIT: if (imem_ack) state <= ST_F;
                ST_F:     state <= ST_D;
                ST_D:     state <= hlt_req ? ST_HALT : ST_E;
                ST_E:     state <= is_mem ? ST_M : ST_W;
                ST_M:     if (dmem_ack) state <= ST_W;
                ST_W: begin
                    retired_q <= retired_q + 32'd1;
                    state     <= ST_FWAIT;
                end
                ST_HALT:  if (start) state <= ST_FWAIT;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        phase    = PH_NONE;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        ir_we    = 1'b0;
        rf_we    = 1'b0;
        hlt      = 1'b0;
        case (state)
            ST_FWAIT: imem_req = 1'b1;
            ST_F: begin
                phase = PH_F;
                ir_we = 1'b1;
            end
            ST_D:     phase = PH_D;
            ST_E:     phase = PH_E;
            ST_M: begin
                phase    = PH_M;
                dmem_req = 1'b1;
            end
            ST_W: begin
                phase = PH_W;
                rf_we = is_wb;
            end
            ST_HALT:  hlt = 1'b1;
            default:  phase = PH_NONE;
        endcase
    end

    assign retired = retired_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer: directed vectors plus a
// per-cycle comparison against a step-name behavioural model.
module tb_phase_sequencer;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        start;
    logic        hlt_req;
    logic        is_mem;
    logic        is_wb;
    logic        imem_ack;
    logic        dmem_ack;
    logic [4:0]  phase;
    logic        imem_req;
    logic        dmem_req;
    logic        ir_we;
    logic        rf_we;
    logic        hlt;
    logic [31:0] retired;

    int checks   = 0;
    int failures = 0;

    string       ms = "UNKNOWN";
    logic [31:0] m_ret = '0;
    logic        m_valid = 1'b0;
    logic        preload_en = 1'b0;
    logic [31:0] preload_val = '0;

    int exp_seq [8] = '{0, 0, 1, 2, 4, 16, 0, 1};

    phase_sequencer dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .start    (start),
        .hlt_req  (hlt_req),
        .is_mem   (is_mem),
        .is_wb    (is_wb),
        .imem_ack (imem_ack),
        .dmem_ack (dmem_ack),
        .phase    (phase),
        .imem_req (imem_req),
        .dmem_req (dmem_req),
        .ir_we    (ir_we),
        .rf_we    (rf_we),
        .hlt      (hlt),
        .retired  (retired)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs just after the edge, return at the following negedge.
    task automatic applyStimulus(input logic rn, input logic st, input logic hr, input logic im,
                                 input logic wb, input logic ia, input logic da);
        @(posedge clk);
        #1;
        n_rst    = rn;
        start    = st;
        hlt_req  = hr;
        is_mem   = im;
        is_wb    = wb;
        imem_ack = ia;
        dmem_ack = da;
        @(negedge clk);
    endtask

    function automatic string next_step(input string s, input logic st, input logic hr,
                                        input logic im, input logic ia, input logic da);
        if (s == "IDLE" || s == "HALT") return st ? "FWAIT" : s;
        if (s == "FWAIT") return ia ? "F" : "FWAIT";
        if (s == "F")     return "D";
        if (s == "D")     return hr ? "HALT" : "E";
        if (s == "E")     return im ? "M" : "W";
        if (s == "M")     return da ? "W" : "M";
        if (s == "W")     return "FWAIT";
        return "UNKNOWN";
    endfunction

    function automatic logic [4:0] exp_phase(input string s);
        if (s == "F") return 5'b00001;
        if (s == "D") return 5'b00010;
        if (s == "E") return 5'b00100;
        if (s == "M") return 5'b01000;
        if (s == "W") return 5'b10000;
        return 5'b00000;
    endfunction

    always @(posedge clk) begin
        if (!n_rst) begin
            ms      <= "IDLE";
            m_ret   <= '0;
            m_valid <= 1'b1;
        end else if (m_valid) begin
            if (preload_en)
                m_ret <= preload_val;
            else if (ms == "W")
                m_ret <= m_ret + 32'd1;
            ms <= next_step(ms, start, hlt_req, is_mem, imem_ack, dmem_ack);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            checkOutput("model_phase", {27'd0, phase}, {27'd0, exp_phase(ms)});
            checkOutput("model_imem_req", {31'd0, imem_req}, {31'd0, ms == "FWAIT"});
            checkOutput("model_dmem_req", {31'd0, dmem_req}, {31'd0, ms == "M"});
            checkOutput("model_ir_we", {31'd0, ir_we}, {31'd0, ms == "F"});
            checkOutput("model_rf_we", {31'd0, rf_we}, {31'd0, (ms == "W") && is_wb});
            checkOutput("model_hlt", {31'd0, hlt}, {31'd0, ms == "HALT"});
            checkOutput("model_retired", retired, m_ret);
            checkOutput("onehot_phase", {31'd0, $onehot0(phase)}, 32'd1);
            checkOutput("exclusive_strobes",
                        {31'd0, $countones({imem_req, dmem_req, ir_we, rf_we}) <= 1}, 32'd1);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cnt_a, cnt_b, cnt_c;
        n_rst = 1'b0; start = 1'b0; hlt_req = 1'b0; is_mem = 1'b0;
        is_wb = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;

        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("reset_phase", {27'd0, phase}, 32'd0);
        checkOutput("reset_retired", retired, 32'd0);
        checkOutput("reset_imem_req", {31'd0, imem_req}, 32'd0);
        checkOutput("reset_hlt", {31'd0, hlt}, 32'd0);

        $display("[TB] basic sequence with imem_ack tied high");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, i == 0, 0, 0, 1, 1, 0);
            checkOutput($sformatf("seq%0d", i), {27'd0, phase}, exp_seq[i]);
            if (i == 5) checkOutput("seq_rf_we_w", {31'd0, rf_we}, 32'd1);
            if (i == 6) checkOutput("seq_retired_first", retired, 32'd1);
        end
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 1, 1, 0);

        $display("[TB] delayed imem_ack");
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 0, 0, 0, 1, i >= 3, 0);
            cnt_a += int'(imem_req);
            cnt_b += int'(phase == 5'b00001);
            cnt_c += int'(ir_we);
        end
        checkOutput("imem_req_cycles", cnt_a, 32'd4);
        checkOutput("phase_f_cycles", cnt_b, 32'd1);
        checkOutput("ir_we_cycles", cnt_c, 32'd1);

        $display("[TB] memory instruction with stalled dmem_ack");
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 0, 0, 1, 0, i == 0, (i == 2) || (i == 6));
            if (i == 0) checkOutput("mem_retired_before", retired, 32'd3);
            cnt_a += int'(phase == 5'b01000);
            cnt_b += int'(dmem_req);
            if (i == 7) begin
                checkOutput("mem_phase_w", {27'd0, phase}, 32'd16);
                checkOutput("mem_rf_we", {31'd0, rf_we}, 32'd0);
            end
        end
        checkOutput("phase_m_cycles", cnt_a, 32'd3);
        checkOutput("dmem_req_cycles", cnt_b, 32'd3);

        $display("[TB] halt and restart");
        cnt_a = 0;
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1, (i == 1) || (i == 5), (i == 1) || (i == 2), 0, 1, i == 0, 0);
            if (i >= 2) cnt_a += int'((phase == 5'b00100) || (phase == 5'b10000));
            if (i == 3) begin
                checkOutput("halt_hlt", {31'd0, hlt}, 32'd1);
                checkOutput("halt_phase", {27'd0, phase}, 32'd0);
            end
            if (i == 5) checkOutput("halt_retired", retired, 32'd4);
            if (i == 6) begin
                checkOutput("restart_hlt", {31'd0, hlt}, 32'd0);
                checkOutput("restart_imem_req", {31'd0, imem_req}, 32'd1);
                checkOutput("restart_retired", retired, 32'd4);
            end
        end
        checkOutput("halt_no_e_or_w", cnt_a, 32'd0);

        $display("[TB] reset during M");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(i != 5, 0, 0, 1, 1, i == 0, i >= 6);
            if (i == 4) checkOutput("midm_dmem_req", {31'd0, dmem_req}, 32'd1);
            if (i == 6) begin
                checkOutput("post_rst_phase", {27'd0, phase}, 32'd0);
                checkOutput("post_rst_dmem_req", {31'd0, dmem_req}, 32'd0);
                checkOutput("post_rst_retired", retired, 32'd0);
            end
            if (i == 7) begin
                checkOutput("late_ack_phase", {27'd0, phase}, 32'd0);
                checkOutput("late_ack_imem_req", {31'd0, imem_req}, 32'd0);
            end
        end

        $display("[TB] retired counter wrap");
        applyStimulus(1, 1, 0, 0, 1, 0, 0);
        #2;
        force dut.retired_q = 32'hFFFF_FFFE;
        preload_val = 32'hFFFF_FFFE;
        preload_en  = 1'b1;
        #1;
        release dut.retired_q;
        for (int j = 0; j < 11; j++) begin
            applyStimulus(1, 0, 0, 0, 1, j != 10, 0);
            preload_en = 1'b0;
            if (j == 0) checkOutput("wrap_preload", retired, 32'hFFFF_FFFE);
            if (j == 5) checkOutput("wrap_max", retired, 32'hFFFF_FFFF);
            if (j == 10) checkOutput("wrap_zero", retired, 32'h0000_0000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
